// File: rtl/ltsm_sb_hs_pkg.sv
// Shared types and constants for the LTSM sideband request/response handshake engine.
// Latency: n/a (types, message codes, timeout default and the counter-width helper).
// Backpressure: n/a.
package ltsm_sb_hs_pkg;

  // TX side: send our request, then wait for the partner's response.
  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND_REQ  = 2'd1,
    TX_WAIT_RESP = 2'd2,
    TX_DONE      = 2'd3
  } tx_state_e;

  // RX side: wait for the partner's request, then send our response.
  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_WAIT_REQ  = 2'd1,
    RX_SEND_RESP = 2'd2,
    RX_DONE      = 2'd3
  } rx_state_e;

  // Encoded sideband message codes used by the LTSM handshakes.
  localparam int PM_L1_ENTRY_REQ        = 8;
  localparam int PM_L1_ENTRY_RESP       = 9;
  localparam int PM_L2_ENTRY_REQ        = 10;
  localparam int PM_L2_ENTRY_RESP       = 11;
  localparam int LINKINIT_EXIT_REQ      = 12;
  localparam int LINKINIT_EXIT_RESP     = 13;
  localparam int TRAINERROR_ENTRY_REQ   = 14;
  localparam int TRAINERROR_ENTRY_RESP  = 15;

  // Default handshake timeout in core cycles.
  localparam int TIMEOUT_DEF = 8000;

  // A zero timeout disables the counter; keep at least one bit so the
  // counter declaration stays legal.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/ltsm_sb_tx_arbiter.sv
// Arbitrates pending REQ/RESP sends onto the single sideband TX message port.
// Latency: a send requested (set pulse) in cycle N with the port free strobes in cycle N+1.
// Backpressure: no launch while busy_i is high or in the cycle right after a strobe;
//   responses win over requests; flush_i drops everything pending and suppresses launch.
// Ports: clk_i/rst_i (sync, active-high); flush_i abort; busy_i TX busy;
//   req_set_i/resp_set_i send requests; req/resp_pend_o pending flags;
//   req/resp_launch_o launch-this-cycle; tx_vld_o/tx_dat_o registered strobe and code.
module ltsm_sb_tx_arbiter #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int REQ_MSG      = 14,
  parameter int RESP_MSG     = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    busy_i,
  input  logic                    req_set_i,
  input  logic                    resp_set_i,
  output logic                    req_pend_o,
  output logic                    resp_pend_o,
  output logic                    req_launch_o,
  output logic                    resp_launch_o,
  output logic                    tx_vld_o,
  output logic [SB_MSG_WIDTH-1:0] tx_dat_o
);

  localparam logic [SB_MSG_WIDTH-1:0] REQ_CODE  = SB_MSG_WIDTH'(REQ_MSG);
  localparam logic [SB_MSG_WIDTH-1:0] RESP_CODE = SB_MSG_WIDTH'(RESP_MSG);

  logic                    req_pend_q, req_pend_d;
  logic                    resp_pend_q, resp_pend_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [SB_MSG_WIDTH-1:0] tx_dat_q, tx_dat_d;
  logic                    req_want, resp_want, slot_free;
  logic                    req_launch, resp_launch;

  always_comb begin
    // A set pulse is eligible in the same cycle so the first launch costs no
    // extra cycle over the registered strobe.
    req_want    = req_pend_q | req_set_i;
    resp_want   = resp_pend_q | resp_set_i;
    // The previous strobe blocks this cycle: guarantees an idle cycle between
    // launches even when busy never rises.
    slot_free   = ~busy_i & ~tx_vld_q & ~flush_i;
    resp_launch = slot_free & resp_want;
    req_launch  = slot_free & req_want & ~resp_want;

    req_pend_d  = ~flush_i & req_want & ~req_launch;
    resp_pend_d = ~flush_i & resp_want & ~resp_launch;

    tx_vld_d    = req_launch | resp_launch;
    tx_dat_d    = '0;
    if (resp_launch) begin
      tx_dat_d = RESP_CODE;
    end else if (req_launch) begin
      tx_dat_d = REQ_CODE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pend_q  <= 1'b0;
      resp_pend_q <= 1'b0;
      tx_vld_q    <= 1'b0;
      tx_dat_q    <= '0;
    end else begin
      req_pend_q  <= req_pend_d;
      resp_pend_q <= resp_pend_d;
      tx_vld_q    <= tx_vld_d;
      tx_dat_q    <= tx_dat_d;
    end
  end

  assign req_pend_o    = req_pend_q;
  assign resp_pend_o   = resp_pend_q;
  assign req_launch_o  = req_launch;
  assign resp_launch_o = resp_launch;
  assign tx_vld_o      = tx_vld_q;
  assign tx_dat_o      = tx_dat_q;

endmodule

// File: rtl/ltsm_sb_hs_engine.sv
// Generic LTSM sideband request/response handshake engine with timeout and initiator-only mode.
// Latency: enable seen with TX not busy -> REQ strobe next cycle; o_hs_end one cycle after both sides DONE.
// Backpressure: i_SB_Busy holds launches; pending sends wait, responses first.
// Ports: i_clk/i_rst (sync, active-high); i_hs_en level enable; i_SB_Busy TX busy;
//   i_rx_msg_valid/i_decoded_SB_msg received code; o_tx_msg_valid/o_encoded_SB_msg
//   launch strobe and code; o_hs_end completion level; o_timeout sticky abort level.
module ltsm_sb_hs_engine
  import ltsm_sb_hs_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int REQ_MSG        = TRAINERROR_ENTRY_REQ,
  parameter int RESP_MSG       = TRAINERROR_ENTRY_RESP,
  parameter int HAS_RX         = 1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_hs_en,
  input  logic                    i_SB_Busy,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_tx_msg_valid,
  output logic                    o_hs_end,
  output logic                    o_timeout
);

  localparam logic [SB_MSG_WIDTH-1:0] REQ_CODE  = SB_MSG_WIDTH'(REQ_MSG);
  localparam logic [SB_MSG_WIDTH-1:0] RESP_CODE = SB_MSG_WIDTH'(RESP_MSG);
  localparam bit                      TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0]        TO_LAST   = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  tx_state_e        tx_q, tx_d;
  rx_state_e        rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs_end_q, hs_end_d;
  logic             to_q, to_d;

  logic rx_req, rx_resp;
  logic both_done, to_fire, flush;
  logic req_set, resp_set;
  logic req_pend, resp_pend, req_launch, resp_launch;

  // Messages only count while the handshake is enabled.
  assign rx_req  = i_hs_en & i_rx_msg_valid & (i_decoded_SB_msg == REQ_CODE);
  assign rx_resp = i_hs_en & i_rx_msg_valid & (i_decoded_SB_msg == RESP_CODE);

  assign both_done = (tx_q == TX_DONE) && (rx_q == RX_DONE);

  // Completion beats timeout when both land in the same cycle.
  assign to_fire = TO_EN && i_hs_en && !hs_end_q && !to_q && !both_done && (cnt_q == TO_LAST);

  // Anything that aborts the handshake also drops pending sends and blocks launch.
  assign flush = ~i_hs_en | to_fire | to_q;

  // ---------------------------------------------------------------------------
  // FSM state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_q <= TX_IDLE;
      rx_q <= RX_IDLE;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      TX_IDLE:      if (i_hs_en) tx_d = TX_SEND_REQ;
      // The request may already have left in the IDLE cycle, in which case the
      // pending flag is clear on arrival here.
      TX_SEND_REQ:  if (!req_pend || req_launch) tx_d = TX_WAIT_RESP;
      TX_WAIT_RESP: if (rx_resp) tx_d = TX_DONE;
      TX_DONE:      tx_d = TX_DONE;
      default:      tx_d = TX_IDLE;
    endcase
    if (to_fire || to_q) tx_d = TX_DONE;
    if (!i_hs_en)        tx_d = TX_IDLE;
  end

  always_comb begin
    rx_d = rx_q;
    if (HAS_RX != 0) begin
      case (rx_q)
        // A request landing on the enable edge is taken straight away.
        RX_IDLE:      if (i_hs_en) rx_d = rx_req ? RX_SEND_RESP : RX_WAIT_REQ;
        RX_WAIT_REQ:  if (rx_req) rx_d = RX_SEND_RESP;
        RX_SEND_RESP: if (!resp_pend || resp_launch) rx_d = RX_DONE;
        RX_DONE:      rx_d = RX_DONE;
        default:      rx_d = RX_IDLE;
      endcase
    end else begin
      // Initiator-only: the responder side is considered finished.
      rx_d = RX_DONE;
    end
    if (to_fire || to_q) rx_d = RX_DONE;
    if (!i_hs_en)        rx_d = RX_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Output logic: send requests to the arbiter, completion and timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    req_set  = (tx_q == TX_IDLE) && i_hs_en;
    resp_set = (HAS_RX != 0) && rx_req && ((rx_q == RX_IDLE) || (rx_q == RX_WAIT_REQ));

    hs_end_d = i_hs_en && both_done && !to_q;
    to_d     = i_hs_en && (to_q || to_fire);

    cnt_d = cnt_q;
    if (!i_hs_en) begin
      cnt_d = '0;
    end else if (TO_EN && !hs_end_q && !to_q && (cnt_q != TO_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      hs_end_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hs_end_q <= hs_end_d;
      to_q     <= to_d;
    end
  end

  ltsm_sb_tx_arbiter #(
    .SB_MSG_WIDTH (SB_MSG_WIDTH),
    .REQ_MSG      (REQ_MSG),
    .RESP_MSG     (RESP_MSG)
  ) u_tx_arbiter (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .flush_i       (flush),
    .busy_i        (i_SB_Busy),
    .req_set_i     (req_set),
    .resp_set_i    (resp_set),
    .req_pend_o    (req_pend),
    .resp_pend_o   (resp_pend),
    .req_launch_o  (req_launch),
    .resp_launch_o (resp_launch),
    .tx_vld_o      (o_tx_msg_valid),
    .tx_dat_o      (o_encoded_SB_msg)
  );

  assign o_hs_end  = hs_end_q;
  assign o_timeout = to_q;

endmodule

// File: tb/tb_ltsm_sb_hs_engine.sv
// Directed bench for ltsm_sb_hs_engine: a bidirectional instance (u_dut) and an
// initiator-only instance (u_ini), both with a 64-cycle timeout, sharing the
// busy and receive inputs but with separate enables.
module tb_ltsm_sb_hs_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic       busy;
  logic       rxv;
  logic [3:0] rxm;

  logic [3:0] code_a, code_b;
  logic       vld_a, vld_b, end_a, end_b, to_a, to_b;

  int errs = 0;
  int nchk = 0;
  int nstb;

  always #5 clk = ~clk;

  ltsm_sb_hs_engine #(
    .SB_MSG_WIDTH(4), .REQ_MSG(14), .RESP_MSG(15), .HAS_RX(1), .TIMEOUT_CYCLES(64)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_hs_en(en_a), .i_SB_Busy(busy),
    .i_rx_msg_valid(rxv), .i_decoded_SB_msg(rxm),
    .o_encoded_SB_msg(code_a), .o_tx_msg_valid(vld_a),
    .o_hs_end(end_a), .o_timeout(to_a)
  );

  ltsm_sb_hs_engine #(
    .SB_MSG_WIDTH(4), .REQ_MSG(14), .RESP_MSG(15), .HAS_RX(0), .TIMEOUT_CYCLES(64)
  ) u_ini (
    .i_clk(clk), .i_rst(rst), .i_hs_en(en_b), .i_SB_Busy(busy),
    .i_rx_msg_valid(rxv), .i_decoded_SB_msg(rxm),
    .o_encoded_SB_msg(code_b), .o_tx_msg_valid(vld_b),
    .o_hs_end(end_b), .o_timeout(to_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs for u_dut, then sample 1 time unit after the edge.
  task automatic step(input logic ea, input logic b, input logic v, input logic [3:0] m);
    en_a = ea;
    busy = b;
    rxv  = v;
    rxm  = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; busy = 1'b0; rxv = 1'b0; rxm = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld_a", vld_a, 0);
    chk("rst_code_a", code_a, 0);
    chk("rst_end_a", end_a, 0);
    chk("rst_to_a", to_a, 0);
    chk("rst_vld_b", vld_b, 0);
    chk("rst_end_b", end_b, 0);
    rst = 1'b0;
    step(0, 0, 0, 4'd0);

    // Basic handshake: REQ out at once, partner REQ at c8, partner RESP at c14.
    step(1, 0, 0, 4'd0);
    chk("basic_req_vld", vld_a, 1);
    chk("basic_req_code", code_a, 14);
    step(1, 0, 0, 4'd0);
    chk("basic_strobe_1cyc", vld_a, 0);
    chk("basic_code_idle", code_a, 0);
    repeat (6) step(1, 0, 0, 4'd0);
    step(1, 0, 1, 4'd14);
    chk("basic_resp_vld", vld_a, 1);
    chk("basic_resp_code", code_a, 15);
    repeat (5) step(1, 0, 0, 4'd0);
    step(1, 0, 1, 4'd15);
    chk("basic_end_early", end_a, 0);
    step(1, 0, 0, 4'd0);
    chk("basic_end", end_a, 1);
    repeat (3) step(1, 0, 0, 4'd0);
    chk("basic_end_held", end_a, 1);
    chk("basic_no_to", to_a, 0);
    step(0, 0, 0, 4'd0);
    chk("basic_en_low_end", end_a, 0);

    // Collision: partner REQ on the enable cycle, busy for 5 cycles.
    step(1, 1, 1, 4'd14);
    nstb = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 4'd0);
      if (vld_a) nstb++;
    end
    chk("coll_busy_hold", nstb + vld_a, 0);
    step(1, 0, 0, 4'd0);
    chk("coll_first_code", code_a, 15);
    chk("coll_first_vld", vld_a, 1);
    step(1, 0, 0, 4'd0);
    chk("coll_gap", vld_a, 0);
    step(1, 0, 0, 4'd0);
    chk("coll_second_code", code_a, 14);
    step(1, 0, 1, 4'd15);
    chk("coll_end_early", end_a, 0);
    step(1, 0, 0, 4'd0);
    chk("coll_end", end_a, 1);
    step(0, 0, 0, 4'd0);

    // RESP while still in SEND_REQ (busy) must be ignored.
    step(1, 1, 0, 4'd0);
    step(1, 1, 1, 4'd15);
    step(1, 1, 1, 4'd14);
    step(1, 0, 0, 4'd0);
    chk("ooo_a_resp_first", code_a, 15);
    step(1, 0, 0, 4'd0);
    step(1, 0, 0, 4'd0);
    chk("ooo_a_req_code", code_a, 14);
    step(1, 0, 0, 4'd0);
    step(1, 0, 0, 4'd0);
    chk("ooo_a_early_resp_ignored", end_a, 0);
    step(0, 0, 0, 4'd0);

    // RESP before partner REQ: TX done, RX still waiting.
    step(1, 0, 0, 4'd0);
    chk("ooo_b_req_code", code_a, 14);
    step(1, 0, 0, 4'd0);
    step(1, 0, 1, 4'd15);
    step(1, 0, 0, 4'd0);
    step(1, 0, 0, 4'd0);
    chk("ooo_b_rx_waiting", end_a, 0);
    step(1, 0, 1, 4'd14);
    chk("ooo_b_resp_code", code_a, 15);
    step(1, 0, 0, 4'd0);
    chk("ooo_b_end_early", end_a, 0);
    step(1, 0, 0, 4'd0);
    chk("ooo_b_end", end_a, 1);
    step(0, 0, 0, 4'd0);

    // Timeout: busy holds the REQ, partner silent.
    nstb = 0;
    for (int i = 0; i < 63; i++) begin
      step(1, 1, 0, 4'd0);
      if (vld_a) nstb++;
    end
    chk("to_pre", to_a, 0);
    step(1, 1, 0, 4'd0);
    chk("to_fire", to_a, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 4'd0);
      if (vld_a) nstb++;
    end
    chk("to_no_strobe", nstb, 0);
    chk("to_held", to_a, 1);
    chk("to_no_end", end_a, 0);
    step(0, 0, 0, 4'd0);
    chk("to_clear", to_a, 0);

    // Initiator-only instance.
    en_b = 1'b1;
    step(0, 0, 0, 4'd0);
    chk("ini_req_vld", vld_b, 1);
    chk("ini_req_code", code_b, 14);
    step(0, 0, 0, 4'd0);
    nstb = 0;
    step(0, 0, 1, 4'd14);
    if (vld_b) nstb++;
    step(0, 0, 0, 4'd0);
    if (vld_b) nstb++;
    chk("ini_no_resp_strobe", nstb, 0);
    step(0, 0, 1, 4'd15);
    chk("ini_end_early", end_b, 0);
    step(0, 0, 0, 4'd0);
    chk("ini_end", end_b, 1);
    en_b = 1'b0;
    step(0, 0, 0, 4'd0);
    chk("ini_en_low", end_b, 0);

    // Reset mid-handshake with REQ and RESP both pending behind busy.
    step(1, 1, 1, 4'd14);
    rst = 1'b1;
    step(1, 1, 0, 4'd0);
    rst = 1'b0;
    chk("rst_mid_vld", vld_a, 0);
    chk("rst_mid_end", end_a, 0);
    chk("rst_mid_to", to_a, 0);
    step(1, 0, 0, 4'd0);
    chk("rst_mid_fresh_code", code_a, 14);
    nstb = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 4'd0);
      if (vld_a) nstb++;
    end
    chk("rst_mid_no_stale", nstb, 0);
    step(0, 0, 0, 4'd0);

    // Enable dropped mid-handshake with both sends pending.
    step(1, 1, 1, 4'd14);
    step(0, 1, 0, 4'd0);
    chk("abort_vld", vld_a, 0);
    step(0, 0, 0, 4'd0);
    chk("abort_no_strobe", vld_a, 0);
    step(1, 0, 0, 4'd0);
    chk("abort_fresh_code", code_a, 14);
    step(0, 0, 0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
